// File: rtl/xq_sched_pkg.sv
// Shared SOML decoder constants and the xQ sequencer state encoding.
package xq_sched_pkg;

  localparam int Q88_W           = 16;
  // Divider pipe latency for the 8.8/8.8 configuration.
  localparam int DIV_LAT_DEFAULT = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_TRACE,
    S_WAIT_DIV,
    S_CAPTURE,
    S_DONE
  } sched_state_e;

endpackage

// File: rtl/xq_sched_cnt.sv
// Loadable up-counter with terminal-count compare, shared by the trace timeout and divider wait.
module xq_sched_cnt #(
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] tc_val_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/xq_sched.sv
// Sequencer running NTERM xQ computations through the shared YGB/trace/divide datapath.
module xq_sched
  import xq_sched_pkg::*;
#(
  parameter  int NTERM   = 4,
  parameter  int W       = Q88_W,
  parameter  int DIV_LAT = DIV_LAT_DEFAULT,
  parameter  int TIMEOUT = 64,
  localparam int IW      = (NTERM > 1) ? $clog2(NTERM) : 1,
  localparam int CW      = $clog2(((TIMEOUT > DIV_LAT) ? TIMEOUT : DIV_LAT) + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  // req/ready: a run starts on any rising edge with req && ready (and no flush);
  // req seen while ready is low is dropped, never queued.
  input  logic             req,
  output logic             ready,
  input  logic             flush,
  output logic [IW-1:0]    dp_sel,
  output logic             dp_start,
  input  logic             dp_finish,
  input  logic [W-1:0]     dp_result,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NTERM*W-1:0] xq,
  output sched_state_e     dbg_state
);

  sched_state_e        state_q;
  logic [IW-1:0]       i_q;
  logic                err_q;
  logic                done_q;
  logic                dp_start_q;
  logic [NTERM*W-1:0]  xq_q;

  logic                cnt_clr, cnt_en, cnt_tc;
  logic [CW-1:0]       cnt_tc_val;
  logic                last_term;

  // The counter runs only in the two wait states; any other state (or a finish) reloads zero.
  always_comb begin
    cnt_en     = ((state_q == S_WAIT_TRACE) && !dp_finish) || (state_q == S_WAIT_DIV);
    cnt_clr    = !cnt_en;
    cnt_tc_val = (state_q == S_WAIT_TRACE) ? CW'(TIMEOUT - 1) : CW'(DIV_LAT - 1);
  end

  assign last_term = (i_q == IW'(NTERM - 1));

  xq_sched_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_val_i (cnt_tc_val),
    .tc_o     (cnt_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      dp_start_q <= 1'b0;
      xq_q       <= '0;
    end else begin
      dp_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (req) begin
              i_q        <= '0;
              err_q      <= 1'b0;
              dp_start_q <= 1'b1;
              state_q    <= S_LAUNCH;
            end
          end
          S_LAUNCH: state_q <= S_WAIT_TRACE;
          S_WAIT_TRACE: begin
            if (dp_finish) begin
              state_q <= S_WAIT_DIV;
            end else if (cnt_tc) begin
              // Abandoned term: zero its word and leave exactly as CAPTURE would.
              err_q            <= 1'b1;
              xq_q[i_q*W +: W] <= '0;
              if (last_term) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                i_q        <= i_q + 1'b1;
                dp_start_q <= 1'b1;
                state_q    <= S_LAUNCH;
              end
            end
          end
          S_WAIT_DIV: begin
            if (cnt_tc) state_q <= S_CAPTURE;
          end
          S_CAPTURE: begin
            xq_q[i_q*W +: W] <= dp_result;
            if (last_term) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              i_q        <= i_q + 1'b1;
              dp_start_q <= 1'b1;
              state_q    <= S_LAUNCH;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign dp_sel    = i_q;
  assign dp_start  = dp_start_q;
  assign done      = done_q;
  assign err       = err_q;
  assign xq        = xq_q;
  assign dbg_state = state_q;

endmodule
